// File: rtl/systolic_ibus_pkg.sv
// Shared types and defaults for the systolic4 ibus arbiter.
package systolic_ibus_pkg;

  localparam int unsigned AwDefault    = 16;
  localparam int unsigned DwDefault    = 16;
  localparam int unsigned RdLatDefault = 1;

  // Master identifier: 0 = host loader, 1 = sequencer/debug port.
  typedef logic mid_t;
  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

  // Bus lock ownership (only used when the lock feature is built in).
  typedef enum logic [1:0] {
    StIdle,
    StLocked0,
    StLocked1
  } lock_state_e;

endpackage

// File: rtl/systolic_ibus_arb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the master that wins a tie.
module rr_arb2
  import systolic_ibus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic freeze_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  mid_t ptr_q, ptr_d;

  // Grant: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt0_o = req0_i;
    gnt1_o = req1_i;
    if (req0_i && req1_i) begin
      gnt0_o = (ptr_q == M0);
      gnt1_o = (ptr_q == M1);
    end
  end

  // Pointer moves to the loser of every grant unless frozen.
  always_comb begin
    ptr_d = ptr_q;
    if (!freeze_i) begin
      if (gnt0_o) begin
        ptr_d = M1;
      end else if (gnt1_o) begin
        ptr_d = M0;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= M0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/systolic_ibus_arb.sv
// Two-master ibus arbiter for systolic4: independent round-robin read/write
// channels, registered issue, in-order read return steered by an owner tag pipe.
// Optional bus lock built in when SYSTOLIC_ARB_LOCK_EN is defined.
module systolic_ibus_arb
  import systolic_ibus_pkg::*;
#(
  parameter int unsigned AW     = AwDefault,
  parameter int unsigned DW     = DwDefault,
  parameter int unsigned RD_LAT = RdLatDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef SYSTOLIC_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          ren,
  output logic [AW-1:0] ibus_radr,
  input  logic [DW-1:0] ibus_rdata,
  output logic          wen,
  output logic [AW-1:0] ibus_wadr,
  output logic [DW-1:0] ibus_wdata
);

  logic allow0, allow1, freeze;
  logic rd_req0, rd_req1, wr_req0, wr_req1;
  logic rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;

  // Requests are masked during reset so no grant is visible while rst_n is low.
  assign rd_req0 = rst_n & allow0 & m0_req & ~m0_we;
  assign rd_req1 = rst_n & allow1 & m1_req & ~m1_we;
  assign wr_req0 = rst_n & allow0 & m0_req & m0_we;
  assign wr_req1 = rst_n & allow1 & m1_req & m1_we;

  rr_arb2 u_rd_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0_i   (rd_req0),
    .req1_i   (rd_req1),
    .freeze_i (freeze),
    .gnt0_o   (rd_gnt0),
    .gnt1_o   (rd_gnt1)
  );

  rr_arb2 u_wr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0_i   (wr_req0),
    .req1_i   (wr_req1),
    .freeze_i (freeze),
    .gnt0_o   (wr_gnt0),
    .gnt1_o   (wr_gnt1)
  );

  assign m0_gnt = rd_gnt0 | wr_gnt0;
  assign m1_gnt = rd_gnt1 | wr_gnt1;

`ifdef SYSTOLIC_ARB_LOCK_EN
  lock_state_e lk_q, lk_d;

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_q <= StIdle;
    end else begin
      lk_q <= lk_d;
    end
  end

  // Lock next state: capture on a locked grant, release once the owner drops lock.
  always_comb begin
    lk_d = lk_q;
    case (lk_q)
      StIdle: begin
        // Both locked grants at once (parallel channels): the read winner owns the bus.
        if (m0_gnt && m0_lock && m1_gnt && m1_lock) begin
          lk_d = rd_gnt0 ? StLocked0 : StLocked1;
        end else if (m0_gnt && m0_lock) begin
          lk_d = StLocked0;
        end else if (m1_gnt && m1_lock) begin
          lk_d = StLocked1;
        end
      end
      StLocked0: if (!m0_lock) lk_d = StIdle;
      StLocked1: if (!m1_lock) lk_d = StIdle;
      default:   lk_d = StIdle;
    endcase
  end

  // Lock outputs: shut out the non-owner and hold both rr pointers.
  always_comb begin
    allow0 = 1'b1;
    allow1 = 1'b1;
    freeze = 1'b0;
    case (lk_q)
      StLocked0: begin
        allow1 = 1'b0;
        freeze = 1'b1;
      end
      StLocked1: begin
        allow0 = 1'b0;
        freeze = 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign allow0 = 1'b1;
  assign allow1 = 1'b1;
  assign freeze = 1'b0;
`endif

  logic          ren_q, ren_d, wen_q, wen_d;
  logic [AW-1:0] radr_q, radr_d, wadr_q, wadr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  mid_t          rd_owner_q, rd_owner_d;

  // Issue next state: winner's fields are launched next cycle, addresses hold when idle.
  always_comb begin
    ren_d      = rd_gnt0 | rd_gnt1;
    wen_d      = wr_gnt0 | wr_gnt1;
    rd_owner_d = rd_gnt1 ? M1 : M0;
    radr_d     = radr_q;
    wadr_d     = wadr_q;
    wdata_d    = wdata_q;
    if (rd_gnt0) begin
      radr_d = m0_adr;
    end else if (rd_gnt1) begin
      radr_d = m1_adr;
    end
    if (wr_gnt0) begin
      wadr_d  = m0_adr;
      wdata_d = m0_wdata;
    end else if (wr_gnt1) begin
      wadr_d  = m1_adr;
      wdata_d = m1_wdata;
    end
  end

  // Issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      rd_owner_q <= M0;
      radr_q     <= '0;
      wadr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      rd_owner_q <= rd_owner_d;
      radr_q     <= radr_d;
      wadr_q     <= wadr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign ren        = ren_q;
  assign wen        = wen_q;
  assign ibus_radr  = radr_q;
  assign ibus_wadr  = wadr_q;
  assign ibus_wdata = wdata_q;

  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;

  // Tag pipe shift: the issued read's owner reaches the last stage as its data arrives.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = ren_q;
    tag_id_d[0]  = rd_owner_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // Tag pipe registers; reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  mid_t          ret_id;
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign ret_id    = tag_id_q[RD_LAT-1];
  assign m0_rvalid = tag_vld_q[RD_LAT-1] & (ret_id == M0);
  assign m1_rvalid = tag_vld_q[RD_LAT-1] & (ret_id == M1);

  // Return data holding registers, loaded on each master's rvalid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= ibus_rdata;
      if (m1_rvalid) rdata1_q <= ibus_rdata;
    end
  end

  // ibus_rdata is only valid in the rvalid cycle, so it is forwarded then and held after.
  assign m0_rdata = m0_rvalid ? ibus_rdata : rdata0_q;
  assign m1_rdata = m1_rvalid ? ibus_rdata : rdata1_q;

endmodule
